// File: rtl/ps2_rx_if.sv
// Read-side handshake between the PS/2 receiver FIFO and its consumer.
// master = receiver (presents bytes), slave = consumer (pops bytes).
interface ps2_rx_if;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: synchronizes ps2_clk/ps2_dat, deserializes
// 11-bit frames, checks stop bit and odd parity, queues good bytes.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start bit (0) on a falling edge
// S_DATA   | shifting 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then push or flag
module ps2_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_dat,
  ps2_rx_if.master                    rd,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  state_t        state;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout, stop_evt, odd_ok;
  logic          ev_push, ev_perr, ev_ferr, ev_ovf;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  // Two-flop synchronizers plus one history flop for ps2_clk edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Frame outcome events; the stop-bit edge and a timeout never coincide
  // because a timeout needs a cycle with no falling edge.
  always_comb begin
    timeout  = (state != S_IDLE) && !fall && (to_cnt == '0);
    stop_evt = (state == S_STOP) && fall;
    odd_ok   = ^{shreg, par_bit};
    ev_ferr  = (stop_evt && !dat_s2) || timeout;
    ev_perr  = stop_evt && dat_s2 && !odd_ok;
    ev_push  = stop_evt && dat_s2 && odd_ok;
  end

  // Frame FSM and inactivity timer; the timer reloads on every falling edge
  // and while idle, and a frame is abandoned when it hits terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
      to_cnt  <= TW'(TIMEOUT_CYCLES);
    end else begin
      if (state == S_IDLE || fall || timeout)
        to_cnt <= TW'(TIMEOUT_CYCLES);
      else
        to_cnt <= to_cnt - 1'b1;

      if (timeout) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state <= S_DATA;
              idx   <= 3'd0;
            end
          end
          S_DATA: begin
            shreg[idx] <= dat_s2;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          S_STOP: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    full    = (count == CW'(FIFO_DEPTH));
    do_pop  = rd.rd_valid && rd.rd_ready;
    do_push = ev_push && (!full || do_pop);
    ev_ovf  = ev_push && full && !do_pop;
  end

  assign rd.rd_valid = (count != '0);
  assign rd.rd_data  = mem[rd_ptr];

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '{default: 8'h00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a same-cycle set beats clear_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= ev_perr | (parity_err & ~clear_err);
      frame_err  <= ev_ferr | (frame_err  & ~clear_err);
      overflow   <= ev_ovf  | (overflow   & ~clear_err);
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: randomized PS/2 frames, a queue-based reference FIFO,
// and a monitor that scores every byte the DUT hands out.
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 5000;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_dat, clear_err;
  logic [3:0] count;
  logic       parity_err, frame_err, overflow;

  ps2_rx_if rd_if ();

  ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd         (rd_if),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clear_err  (clear_err)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         exp_perr, exp_ferr, exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the head of the reference queue.
  always @(negedge clock) begin
    if (reset === 1'b0 && rd_if.rd_valid === 1'b1 && rd_if.rd_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h expected no data", rd_if.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_if.rd_data !== mon_exp) begin
          bad++;
          $display("FAIL pop_data: got %0h expected %0h", rd_if.rd_data, mon_exp);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // strobe: 0 none, 1 rd_ready, 2 clear_err, asserted for exactly the
  // cycle in which the stop-bit outcome is registered.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int strobe);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      wait_cyc($urandom_range(2, 6));
      ps2_clk = 1'b0;
      if (i == 10 && strobe != 0) begin
        wait_cyc(2);
        if (strobe == 1) rd_if.rd_ready = 1'b1; else clear_err = 1'b1;
        wait_cyc(1);
        rd_if.rd_ready = 1'b0;
        clear_err      = 1'b0;
      end else begin
        wait_cyc($urandom_range(2, 6));
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(8);
  endtask

  // Reference model: what a complete frame should do to queue and flags.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int strobe);
    if (strobe == 2) begin
      exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
    end
    if (bad_stop) exp_ferr = 1;
    else if (bad_par) exp_perr = 1;
    else if (exp_q.size() < DEPTH || strobe == 1) exp_q.push_back(b);
    else exp_ovf = 1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int strobe);
    send_frame(b, bad_par, bad_stop, 11, strobe);
    model_frame(b, bad_par, bad_stop, strobe);
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, count, exp_q.size());
    check({name, "_valid"}, rd_if.rd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check({name, "_data"}, rd_if.rd_data, exp_q[0]);
    check({name, "_perr"}, parity_err, exp_perr);
    check({name, "_ferr"}, frame_err, exp_ferr);
    check({name, "_ovf"}, overflow, exp_ovf);
  endtask

  task automatic pop_one();
    rd_if.rd_ready = 1'b1;
    wait_cyc(1);
    rd_if.rd_ready = 1'b0;
    wait_cyc(1);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && rd_if.rd_valid; k++) pop_one();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    wait_cyc(1);
    clear_err = 1'b0;
    exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         kind;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    clear_err = 1'b0; rd_if.rd_ready = 1'b0;
    wait_cyc(3);
    check_state("reset");
    check("reset_rd_data", rd_if.rd_data, 8'h00);
    reset = 1'b0;
    wait_cyc(3);

    // single good frame, then pop
    frame(8'h1C, 0, 0, 0);
    check_state("good_1c");
    pop_one();
    check_state("good_pop");

    // back-to-back
    frame(8'hF0, 0, 0, 0);
    frame(8'h1C, 0, 0, 0);
    check_state("b2b");
    drain();
    check_state("b2b_drained");

    // parity error, clear, clear colliding with a new parity error
    frame(8'h1C, 1, 0, 0);
    check_state("perr");
    pulse_clear();
    check_state("perr_cleared");
    frame(8'h1C, 1, 0, 2);
    check_state("perr_clr_same");

    // stop error, overflow, push+pop while full
    pulse_clear();
    frame(8'h1C, 0, 1, 0);
    check_state("stop_err");
    pulse_clear();
    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, 0);
    check_state("overflow");
    drain();
    check_state("ovf_drained");
    pulse_clear();
    for (int i = 1; i <= 8; i++) frame(8'(8'h10 + i), 0, 0, 0);
    frame(8'h19, 0, 0, 1);
    check_state("full_pushpop");
    drain();
    check_state("full_drained");

    // timeout on a partial frame
    send_frame(8'hA5, 0, 0, 5, 0);
    wait_cyc(TMO - 100);
    check("tmo_early_ferr", frame_err, 1'b0);
    wait_cyc(200);
    exp_ferr = 1;
    check_state("timeout");
    frame(8'h5A, 0, 0, 0);
    check_state("after_tmo");
    drain();
    pulse_clear();

    // randomized frames with occasional errors and pops
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 5);
      frame(rb, kind == 0, kind == 1, 0);
      if ($urandom_range(0, 2) == 0 && rd_if.rd_valid) pop_one();
      check_state("rand");
      if ($urandom_range(0, 5) == 0) pulse_clear();
    end
    drain();
    check_state("rand_drained");

    // reset in the middle of a frame with data queued and a flag set
    frame(8'h33, 0, 0, 0);
    frame(8'h1C, 1, 0, 0);
    send_frame(8'h77, 0, 0, 6, 0);
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_perr = 0; exp_ferr = 0; exp_ovf = 0;
    check_state("mid_reset");
    check("mid_reset_rd_data", rd_if.rd_data, 8'h00);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    frame(8'h1C, 0, 0, 0);
    check_state("post_reset");
    drain();
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Host-side PS/2 receiver. Samples the device-driven ps2_clk/ps2_dat pair and deserializes 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Checks each frame and pushes valid scan-code bytes into a small FIFO.
- Sits between the keyboard device model / pad and the SoC peripheral bus wrapper, which pops bytes through a valid/ready port.

Parameters:
- FIFO_DEPTH, 8, byte entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 5000, clock cycles with no ps2_clk falling edge before a partial frame is abandoned (200 us at 25 MHz).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock from the device; asynchronous to clock; idles high.
- ps2_dat  input  1  PS/2 data from the device; asynchronous to clock; idles high.
- rd_valid  output  1  FIFO non-empty; rd_data is valid.
- rd_data  output  8  byte at the FIFO head.
- rd_ready  input  1  consumer pops the head when rd_valid && rd_ready at a rising clock edge.
- count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- parity_err  output  1  sticky; a frame failed odd parity.
- frame_err  output  1  sticky; bad stop bit or timeout.
- overflow  output  1  sticky; a good byte was dropped because the FIFO was full.
- clear_err  input  1  clears all three sticky flags.

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops and edge-history flop go to 1.
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - rd_valid=0, rd_data=0, all flags 0.
  - Reset asserted mid-frame discards the partial frame.
- Input conditioning: ps2_clk and ps2_dat each pass through a 2-flop synchronizer. A falling edge is detected when the synchronized clock is 0 and its previous-cycle value is 1. Data is sampled from synchronized ps2_dat in the same cycle as the detected edge.
- Minimum supported ps2_clk phase is 2 clock cycles high and 2 low; the 6.25 MHz simulation keyboard is the worst case.
- FSM, advancing only on a detected falling edge:
  - IDLE: sampled bit 0 -> DATA, bit index=0. Sampled 1 -> stay IDLE as a glitch, no flag.
  - DATA: shift bit into data[idx]; after idx 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: evaluate the stop bit and parity, then -> IDLE:
    - stop bit 0 -> drop byte, set frame_err (frame_err takes precedence over parity_err);
    - odd parity fails -> drop byte, set parity_err;
    - otherwise push the byte.
- Timeout:
  - In any non-IDLE state, a counter increments every clock and clears on each detected falling edge.
  - When it reaches TIMEOUT_CYCLES -> IDLE, partial byte discarded, frame_err set.
  - The counter is held at 0 in IDLE.
- Push latency: the byte is written at the clock edge following the cycle in which the stop-bit falling edge is detected. rd_valid and count update in that same cycle and are visible one cycle later.
- FIFO:
  - rd_data is driven from the head entry, combinationally from the registered read pointer.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full with no pop in that cycle: byte dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push into an empty FIFO: no same-cycle pop is possible because rd_valid is still 0.
  - rd_ready with rd_valid=0 is ignored.
- Sticky flags: clear_err clears all three flags; a set event in the same cycle as clear_err wins (flag stays 1).

Test Plan:
- Good frame: send 0x1C (bits 0,0,0,1,1,1,0,0,0,par=0,stop=1) with rd_ready=0 -> rd_valid=1, rd_data=0x1C, count=1, no flags; pulse rd_ready for one cycle -> rd_valid=0, count=0.
- Back-to-back frames: send 0xF0 (par=1) then 0x1C -> pops return 0xF0 then 0x1C in order, all flags 0.
- Parity error: send 0x1C with par=1 -> nothing pushed, count=0, parity_err=1. Pulse clear_err -> parity_err=0. Assert clear_err in the same cycle as a new parity error -> parity_err stays 1.
- Stop error and overflow:
  - send 0x1C with stop=0 -> frame_err=1, count=0;
  - clear_err, then send 9 good frames 0x01..0x09 with rd_ready=0 -> count=8, overflow=1, pops return 0x01..0x08;
  - full FIFO with rd_ready=1 during the 9th push -> count stays 8, overflow=0.
- Timeout: send start plus 4 data bits, hold ps2_clk high for TIMEOUT_CYCLES -> frame_err=1, FSM in IDLE; a following good frame 0x5A is received correctly.
- Reset mid-frame: assert reset after 6 bits of a frame -> all outputs 0 immediately. Release reset, send a good 0x1C -> received correctly, no flags.
